// File: rtl/tank_bullet.sv
// Bullet pool: spawns on fire+frame tick, moves live bullets each frame, drives a per-pixel mask.
// Define TANK_BULLET_COOLDOWN_EN to block spawning for COOLDOWN_FRAMES ticks after each spawn.
module tank_bullet #(
  parameter int NUM_BULLETS     = 4,
  parameter int BULLET_SIZE     = 4,
  parameter int BULLET_SPEED    = 4,
  parameter int TANK_SIZE       = 32,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   is_shooting,
  input  logic [2:0]             tank_dir,
  input  logic [9:0]             tank_X,
  input  logic [9:0]             tank_Y,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic                   is_bullet,
  output logic [NUM_BULLETS-1:0] bullet_active,
  output logic [3:0]             bullet_count,
  output logic                   fire_ack
);

  localparam logic [2:0]  DIR_UP    = 3'd1;
  localparam logic [2:0]  DIR_RIGHT = 3'd2;
  localparam logic [2:0]  DIR_LEFT  = 3'd3;
  localparam logic [2:0]  DIR_DOWN  = 3'd4;
  localparam logic [10:0] SZ        = 11'(BULLET_SIZE);
  localparam logic [10:0] SPD       = 11'(BULLET_SPEED);
  localparam logic [9:0]  SPD10     = 10'(BULLET_SPEED);
  localparam logic [10:0] TS        = 11'(TANK_SIZE);
  localparam logic [10:0] HOFF      = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] XLIM      = 11'(X_MAX + 1);
  localparam logic [10:0] YLIM      = 11'(Y_MAX + 1);
  localparam logic [10:0] XSP_MAX   = 11'(X_MAX - BULLET_SIZE + 1);
  localparam logic [10:0] YSP_MAX   = 11'(Y_MAX - BULLET_SIZE + 1);

  if (NUM_BULLETS < 1 || NUM_BULLETS > 8 || COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES > 15) begin : g_param_bad
    $error("tank_bullet: parameter out of range");
  end

  logic [1:0]             fsync_q;
  logic                   tick;
  logic                   fire_req_q, fire_req_d;
  logic                   fire_ack_q;
  logic [NUM_BULLETS-1:0] active_q, active_d, free_oh;
  logic [9:0]             x_q [NUM_BULLETS];
  logic [9:0]             x_d [NUM_BULLETS];
  logic [9:0]             y_q [NUM_BULLETS];
  logic [9:0]             y_d [NUM_BULLETS];
  logic [2:0]             dir_q [NUM_BULLETS];
  logic [2:0]             dir_d [NUM_BULLETS];
  logic [3:0]             count_q, count_d;
  logic [10:0]            sp_x, sp_y;
  logic                   sp_ok, free_vld, gate, spawn;

  assign tick       = fsync_q[0] & ~fsync_q[1];
  assign fire_req_d = is_shooting | (fire_req_q & ~tick);

  // Spawn position from the live tank inputs; negative coordinates are caught before subtraction.
  always_comb begin
    sp_x  = {1'b0, tank_X};
    sp_y  = {1'b0, tank_Y};
    sp_ok = 1'b1;
    case (tank_dir)
      DIR_UP: begin
        sp_x = {1'b0, tank_X} + HOFF;
        if ({1'b0, tank_Y} < SZ) sp_ok = 1'b0;
        else                     sp_y  = {1'b0, tank_Y} - SZ;
      end
      DIR_DOWN: begin
        sp_x = {1'b0, tank_X} + HOFF;
        sp_y = {1'b0, tank_Y} + TS;
      end
      DIR_LEFT: begin
        if ({1'b0, tank_X} < SZ) sp_ok = 1'b0;
        else                     sp_x  = {1'b0, tank_X} - SZ;
        sp_y = {1'b0, tank_Y} + HOFF;
      end
      DIR_RIGHT: begin
        sp_x = {1'b0, tank_X} + TS;
        sp_y = {1'b0, tank_Y} + HOFF;
      end
      default: sp_ok = 1'b0;
    endcase
    if (sp_x > XSP_MAX || sp_y > YSP_MAX) sp_ok = 1'b0;
  end

  always_comb begin
    free_oh  = '0;
    free_vld = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_q[i] && !free_vld) begin
        free_oh[i] = 1'b1;
        free_vld   = 1'b1;
      end
    end
  end

`ifdef TANK_BULLET_COOLDOWN_EN
  logic [3:0] cd_q, cd_d;

  assign gate = (cd_q == 4'd0);

  always_comb begin
    cd_d = cd_q;
    if (spawn)                       cd_d = 4'(COOLDOWN_FRAMES);
    else if (tick && cd_q != 4'd0)   cd_d = cd_q - 4'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cd_q <= 4'd0;
    else          cd_q <= cd_d;
  end
`else
  assign gate = 1'b1;
`endif

  assign spawn = tick & fire_req_q & gate & free_vld & sp_ok;

  // Move or retire every live slot; the spawn lands only in a slot that was free, so no overlap.
  always_comb begin
    active_d = active_q;
    count_d  = 4'd0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      dir_d[i] = dir_q[i];
      if (tick && active_q[i]) begin
        case (dir_q[i])
          DIR_UP:
            if ({1'b0, y_q[i]} < SPD) active_d[i] = 1'b0;
            else                      y_d[i]      = y_q[i] - SPD10;
          DIR_DOWN:
            if ({1'b0, y_q[i]} + SPD + SZ > YLIM) active_d[i] = 1'b0;
            else                                  y_d[i]      = y_q[i] + SPD10;
          DIR_LEFT:
            if ({1'b0, x_q[i]} < SPD) active_d[i] = 1'b0;
            else                      x_d[i]      = x_q[i] - SPD10;
          DIR_RIGHT:
            if ({1'b0, x_q[i]} + SPD + SZ > XLIM) active_d[i] = 1'b0;
            else                                  x_d[i]      = x_q[i] + SPD10;
          default: ;
        endcase
      end
      if (spawn && free_oh[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = sp_x[9:0];
        y_d[i]      = sp_y[9:0];
        dir_d[i]    = tank_dir;
      end
      count_d = count_d + 4'(active_d[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync_q    <= 2'b00;
      fire_req_q <= 1'b0;
      fire_ack_q <= 1'b0;
      active_q   <= '0;
      count_q    <= 4'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]   <= 10'd0;
        y_q[i]   <= 10'd0;
        dir_q[i] <= 3'd0;
      end
    end else begin
      fsync_q    <= {fsync_q[0], frame_clk};
      fire_req_q <= fire_req_d;
      fire_ack_q <= spawn;
      active_q   <= active_d;
      count_q    <= count_d;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

  always_comb begin
    is_bullet = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active_q[i] &&
          {1'b0, DrawX} >= {1'b0, x_q[i]} && {1'b0, DrawX} <= {1'b0, x_q[i]} + SZ - 11'd1 &&
          {1'b0, DrawY} >= {1'b0, y_q[i]} && {1'b0, DrawY} <= {1'b0, y_q[i]} + SZ - 11'd1)
        is_bullet = 1'b1;
    end
  end

  assign bullet_active = active_q;
  assign bullet_count  = count_q;
  assign fire_ack      = fire_ack_q;

endmodule

// File: tb/tb_tank_bullet.sv
// Scoreboard bench for tank_bullet: expectations queued at stimulus time, popped as outputs are observed.
module tb_tank_bullet;
  localparam int NB = 4;

  logic          Clk;
  logic          Reset_n;
  logic          frame_clk;
  logic          is_shooting;
  logic [2:0]    tank_dir;
  logic [9:0]    tank_X, tank_Y, DrawX, DrawY;
  logic          is_bullet;
  logic [NB-1:0] bullet_active;
  logic [3:0]    bullet_count;
  logic          fire_ack;

  int    n_chk  = 0;
  int    n_pass = 0;
  string tag_q[$];
  int    exp_q[$];

  tank_bullet dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .is_shooting(is_shooting),
    .tank_dir(tank_dir), .tank_X(tank_X), .tank_Y(tank_Y), .DrawX(DrawX), .DrawY(DrawY),
    .is_bullet(is_bullet), .bullet_active(bullet_active), .bullet_count(bullet_count),
    .fire_ack(fire_ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input int obs);
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL sb_empty: got %0d, expected nothing queued", obs);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic probe(input int x, input int y, output int hit);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    hit = int'(is_bullet);
  endtask

  // Corner-inside and just-outside probes around a bullet whose top-left is (x,y).
  task automatic expect_slot(input string tag, input int x, input int y);
    sb_push({tag, "_in_tl"}, 1);
    sb_push({tag, "_in_br"}, 1);
    sb_push({tag, "_out_l"}, 0);
    sb_push({tag, "_out_r"}, 0);
  endtask

  task automatic observe_slot(input int x, input int y);
    int h;
    probe(x, y, h);         sb_pop(h);
    probe(x + 3, y + 3, h); sb_pop(h);
    probe(x - 1, y, h);     sb_pop(h);
    probe(x + 4, y + 3, h); sb_pop(h);
  endtask

  task automatic fire();
    is_shooting = 1'b1;
    @(negedge Clk);
    is_shooting = 1'b0;
  endtask

  task automatic do_tick(output int acks);
    acks = 0;
    frame_clk = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (fire_ack) acks++;
    end
    frame_clk = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (fire_ack) acks++;
    end
  endtask

  task automatic reset_dut();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, h, exp_ack;
    Reset_n = 1'b0; frame_clk = 1'b0; is_shooting = 1'b0;
    tank_dir = 3'd0; tank_X = 10'd0; tank_Y = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(negedge Clk);

    sb_push("rst_active", 0); sb_push("rst_count", 0); sb_push("rst_ack", 0); sb_push("rst_hit", 0);
    sb_pop(int'(bullet_active)); sb_pop(int'(bullet_count)); sb_pop(int'(fire_ack)); sb_pop(int'(is_bullet));
    Reset_n = 1'b1;
    @(negedge Clk);

    // Up shot, then tank moves away; bullet keeps its own track.
    tank_X = 10'd500; tank_Y = 10'd240; tank_dir = 3'd1;
    sb_push("up_ack", 1); sb_push("up_count", 1); sb_push("up_active", 1);
    expect_slot("up_spawn", 514, 236);
    fire(); do_tick(acks);
    sb_pop(acks); sb_pop(int'(bullet_count)); sb_pop(int'(bullet_active));
    observe_slot(514, 236);
    tank_X = 10'd100; tank_Y = 10'd50; tank_dir = 3'd2;
    sb_push("up_count2", 1);
    expect_slot("up_move2", 514, 228);
    do_tick(acks); do_tick(acks);
    sb_pop(int'(bullet_count));
    observe_slot(514, 228);

    reset_dut();
    // Left shot near the edge: move once, then retire.
    tank_X = 10'd10; tank_Y = 10'd100; tank_dir = 3'd3;
    sb_push("left_ack", 1);
    expect_slot("left_spawn", 6, 114);
    fire(); do_tick(acks);
    sb_pop(acks); observe_slot(6, 114);
    expect_slot("left_move", 2, 114);
    do_tick(acks);
    observe_slot(2, 114);
    sb_push("left_ret_count", 0); sb_push("left_ret_active", 0);
    do_tick(acks);
    sb_pop(int'(bullet_count)); sb_pop(int'(bullet_active));

    reset_dut();
    // Fire before every tick for 20 ticks heading right; pool limit or cooldown governs spawns.
    tank_X = 10'd300; tank_Y = 10'd200; tank_dir = 3'd2;
    for (int t = 1; t <= 20; t++) begin
`ifdef TANK_BULLET_COOLDOWN_EN
      exp_ack = (t % 9 == 1) ? 1 : 0;
`else
      exp_ack = (t <= NB) ? 1 : 0;
`endif
      sb_push($sformatf("burst_ack_t%0d", t), exp_ack);
      fire(); do_tick(acks);
      sb_pop(acks);
    end
`ifdef TANK_BULLET_COOLDOWN_EN
    sb_push("burst_count", 3); sb_push("burst_active", 7);
`else
    sb_push("burst_count", 4); sb_push("burst_active", 15);
`endif
    sb_pop(int'(bullet_count)); sb_pop(int'(bullet_active));

    reset_dut();
    // Off-screen spawn is suppressed and the request does not linger.
    tank_X = 10'd0; tank_Y = 10'd0; tank_dir = 3'd1;
    sb_push("supp_ack", 0); sb_push("supp_count", 0);
    fire(); do_tick(acks);
    sb_pop(acks); sb_pop(int'(bullet_count));
    tank_dir = 3'd2;
    sb_push("supp_req_clr_ack", 0); sb_push("supp_req_clr_count", 0);
    do_tick(acks);
    sb_pop(acks); sb_pop(int'(bullet_count));
    tank_X = 10'd300; tank_Y = 10'd200; tank_dir = 3'd0;
    sb_push("bad_dir_ack", 0); sb_push("bad_dir_count", 0);
    fire(); do_tick(acks);
    sb_pop(acks); sb_pop(int'(bullet_count));

    reset_dut();
    // Pixel mask edges at (300,200), then asynchronous reset mid-flight.
    tank_X = 10'd268; tank_Y = 10'd186; tank_dir = 3'd2;
    sb_push("mask_ack", 1);
    sb_push("mask_303_203", 1); sb_push("mask_304_203", 0);
    sb_push("mask_300_200", 1); sb_push("mask_300_204", 0);
    fire(); do_tick(acks);
    sb_pop(acks);
    probe(303, 203, h); sb_pop(h);
    probe(304, 203, h); sb_pop(h);
    probe(300, 200, h); sb_pop(h);
    probe(300, 204, h); sb_pop(h);
    @(negedge Clk);
    #1;
    sb_push("arst_active", 0); sb_push("arst_count", 0); sb_push("arst_hit", 0);
    Reset_n = 1'b0;
    DrawX = 10'd300; DrawY = 10'd200;
    #1;
    sb_pop(int'(bullet_active)); sb_pop(int'(bullet_count)); sb_pop(int'(is_bullet));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    if (exp_q.size() != 0) check_eq("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
